vga_window_timing: RTL and testbench
====================================

# vga_window_timing

Parametrised successor to the fixed 800x600 VGA generator. It produces horizontal and vertical timing with configurable active, porch and sync lengths and sync polarities. It places one ROM-backed image window at a run-time position and fills the rest of the active area with a run-time background colour. The block drives the 3-3-2 RGB pins and the syncs directly, and reads pixel data from an external synchronous image ROM through an address/data port.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 40 / 128 / 88, horizontal front porch / sync / back porch (H_TOTAL = 1056)
- V_ACTIVE, 600, visible lines
- V_FP / V_SYNC / V_BP, 1 / 4 / 23, vertical porches and sync (V_TOTAL = 628)
- HS_ACTIVE_HIGH / VS_ACTIVE_HIGH, 0 / 0, sync pulse polarity (0 = low pulse)
- IMG_W / IMG_H, 168 / 192, image size in pixels
- ADDR_W, 16, ROM address width; IMG_W*IMG_H must be at most 2^ADDR_W
- Ports:
  - clk  in  1  pixel clock
  - reset  in  1  asynchronous, active-low reset
  - img_x  in  11  window left column
  - img_y  in  10  window top line
  - bg_color  in  8  colour for active pixels outside the window
  - rom_addr  out  ADDR_W  registered image ROM address
  - rom_data  in  8  ROM pixel, valid one cycle after rom_addr
  - red / green / blue  out  3 / 3 / 2  registered colour, taken as rom_data[7:5] / [4:2] / [1:0] or bg_color likewise
  - hsync / vsync  out  1  registered syncs
  - frame_start  out  1  one-cycle pulse, aligned with pin pixel (0,0)
  - hcount / vcount  out  11 / 10  raw counter values (stage 0)

## Operation
- hcount runs 0..H_TOTAL-1 and wraps.
- vcount increments when hcount wraps, and itself wraps at V_TOTAL-1.
- hsync is asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule in the vertical direction. Polarity comes from the parameters.
- active = hcount < H_ACTIVE && vcount < V_ACTIVE.
- Window position: img_x and img_y are latched into wx and wy when hcount = H_TOTAL-1 and vcount = V_TOTAL-1. Changes made mid-frame are therefore ignored until the next frame.
- in_win = hcount in [wx, wx+IMG_W) && vcount in [wy, wy+IMG_H). Comparisons use 12-bit arithmetic so that wx+IMG_W does not wrap.
- Address generation (no multiplier):
  - row_base is cleared at frame latch.
  - row_base += IMG_W at hcount = H_TOTAL-1 on every line where vcount is in the window.
  - rom_addr = row_base + (hcount - wx) when in_win; otherwise rom_addr holds its value.
- Clipping: window pixels that fall outside the active area are never shown, but addressing stays correct for visible pixels (row_base advances regardless).
- Pixel select at stage 2: in_win → rom_data; active but not in_win → bg_color; blanking → 0.
- Reset values: counters 0, rom_addr 0, rgb 0, hsync/vsync at their inactive level, frame_start 0, wx/wy 0, row_base 0.

## Timing
- Stage 0 (counters) → stage 1 (rom_addr, in_win, active, sync flags registered) → stage 2 (rgb, hsync, vsync, frame_start registered).
- Counter value (h,v) therefore appears on the pins exactly 2 cycles later. Syncs are delayed identically, so they stay aligned with pixels.
- The ROM has exactly one cycle of latency. rom_data is sampled in stage 2 for the address issued in stage 1.
- Reset asserted at any time, including mid-line or mid-frame: all registers clear immediately (asynchronously). Counting resumes from (0,0) on the first clk edge after reset deasserts, and the first frame_start reaches the pins 2 cycles after that.
- Counter state (h,v) = (H_TOTAL-1, V_TOTAL-1) produces the frame latch and both counter wraps on the same edge.

## Structure
- Package vga_pkg holds:
  - the 800x600@60 timing constants (as default parameter values);
  - the RGB332 field positions;
  - a typedef for the colour byte.
- One sub-module, vga_timing_counter, contains the parametrised h/v counters and the sync/active decode. It is reusable by other video blocks.
- The top level keeps the window logic, address generation and pixel pipeline.
- The ROM stays outside the block.

## Test plan
- Release reset: hsync goes low at cycle 842 after release and stays low 128 cycles. The line period is 1056 cycles.
- Full frame: vsync is low for 4*1056 cycles starting at line 601. frame_start repeats every 663168 cycles.
- img_x = img_y = 10, ROM modelled as data = addr[7:0]:
  - pin pixel (10,10) = ROM[0];
  - pin pixel (177,10) = ROM[167];
  - pin pixel (10,11) = ROM[168];
  - the last window pixel, (177,201), uses address 32255;
  - pin pixel (9,10) = bg_color 0x04.
- Clipping with img_x = 700: pins show black for columns 800 onward. Line 11 starts at address 168.
- Move img_x mid-frame: the window does not shift until the line after the next frame_start.
- Small-parameter instance (H 8/2/2/2, V 4/1/1/1, active-high syncs) plus reset pulsed mid-line: all outputs go to reset values immediately, and timing restarts cleanly.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared video constants: 800x600@60 default timing and RGB332 colour layout.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 800;
    localparam int unsigned H_FP_DEF     = 40;
    localparam int unsigned H_SYNC_DEF   = 128;
    localparam int unsigned H_BP_DEF     = 88;
    localparam int unsigned V_ACTIVE_DEF = 600;
    localparam int unsigned V_FP_DEF     = 1;
    localparam int unsigned V_SYNC_DEF   = 4;
    localparam int unsigned V_BP_DEF     = 23;

    localparam int unsigned RED_MSB = 7;
    localparam int unsigned RED_LSB = 5;
    localparam int unsigned GRN_MSB = 4;
    localparam int unsigned GRN_LSB = 2;
    localparam int unsigned BLU_MSB = 1;
    localparam int unsigned BLU_LSB = 0;

    typedef logic [7:0] rgb332_t;

endpackage

// File: rtl/vga_timing_counter.sv
// Parametrised h/v raster counters with sync and active-area decode.
// Sync outputs are polarity-free flags; the consumer applies polarity.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned HW       = 11,
    parameter int unsigned VW       = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic [HW-1:0] hcount_o,
    output logic [VW-1:0] vcount_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          active_o,
    output logic          line_end_o,
    output logic          frame_end_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;

    always_comb begin
        line_end_o  = (hcount_q == H_LAST);
        frame_end_o = line_end_o && (vcount_q == V_LAST);
        hcount_d    = line_end_o ? '0 : hcount_q + HW'(1);
        vcount_d    = vcount_q;
        if (line_end_o) begin
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount_o = hcount_q;
    assign vcount_o = vcount_q;
    assign hsync_o  = (hcount_q >= HS_START) && (hcount_q < HS_END);
    assign vsync_o  = (vcount_q >= VS_START) && (vcount_q < VS_END);
    assign active_o = (hcount_q < H_ACT) && (vcount_q < V_ACT);

endmodule

// File: rtl/vga_window_timing.sv
// VGA generator with one ROM-backed image window over a background colour.
// Three-stage pipeline: counters -> ROM address/flags -> pins.
module vga_window_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE       = H_ACTIVE_DEF,
    parameter int unsigned H_FP           = H_FP_DEF,
    parameter int unsigned H_SYNC         = H_SYNC_DEF,
    parameter int unsigned H_BP           = H_BP_DEF,
    parameter int unsigned V_ACTIVE       = V_ACTIVE_DEF,
    parameter int unsigned V_FP           = V_FP_DEF,
    parameter int unsigned V_SYNC         = V_SYNC_DEF,
    parameter int unsigned V_BP           = V_BP_DEF,
    parameter bit          HS_ACTIVE_HIGH = 1'b0,
    parameter bit          VS_ACTIVE_HIGH = 1'b0,
    parameter int unsigned IMG_W          = 168,
    parameter int unsigned IMG_H          = 192,
    parameter int unsigned ADDR_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       img_x,
    input  logic [9:0]        img_y,
    input  logic [7:0]        bg_color,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [1:0]        blue,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start,
    output logic [10:0]       hcount,
    output logic [9:0]        vcount
);

    localparam logic [11:0]       IMG_W12  = 12'(IMG_W);
    localparam logic [11:0]       IMG_H12  = 12'(IMG_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    logic [10:0] h;
    logic [9:0]  v;
    logic        hs_flag, vs_flag, act, line_end, frame_end;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (11),
        .VW       (10)
    ) u_counter (
        .clk_i       (clk),
        .rst_ni      (reset),
        .hcount_o    (h),
        .vcount_o    (v),
        .hsync_o     (hs_flag),
        .vsync_o     (vs_flag),
        .active_o    (act),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    logic [10:0]       wx_q, wx_d;
    logic [9:0]        wy_q, wy_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              h_in, v_in, in_win;
    logic              in_win_q, active_q, hs_q, vs_q, fs_q;
    rgb332_t           pix_q, pix_d;
    logic              hsync_q, vsync_q, frame_start_q;

    // 12-bit compares keep wx+IMG_W from wrapping near the right edge.
    always_comb begin
        h_in   = ({1'b0, h} >= {1'b0, wx_q}) && ({1'b0, h} < ({1'b0, wx_q} + IMG_W12));
        v_in   = ({2'b0, v} >= {2'b0, wy_q}) && ({2'b0, v} < ({2'b0, wy_q} + IMG_H12));
        in_win = h_in && v_in;

        wx_d       = wx_q;
        wy_d       = wy_q;
        row_base_d = row_base_q;
        if (frame_end) begin
            wx_d       = img_x;
            wy_d       = img_y;
            row_base_d = '0;
        end else if (line_end && v_in) begin
            row_base_d = row_base_q + ROW_STEP;
        end

        rom_addr_d = in_win ? row_base_q + ADDR_W'(h - wx_q) : rom_addr_q;

        if (!active_q) begin
            pix_d = '0;
        end else if (in_win_q) begin
            pix_d = rom_data;
        end else begin
            pix_d = bg_color;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wx_q          <= '0;
            wy_q          <= '0;
            row_base_q    <= '0;
            rom_addr_q    <= '0;
            in_win_q      <= 1'b0;
            active_q      <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            fs_q          <= 1'b0;
            pix_q         <= '0;
            hsync_q       <= ~HS_ACTIVE_HIGH;
            vsync_q       <= ~VS_ACTIVE_HIGH;
            frame_start_q <= 1'b0;
        end else begin
            wx_q          <= wx_d;
            wy_q          <= wy_d;
            row_base_q    <= row_base_d;
            rom_addr_q    <= rom_addr_d;
            in_win_q      <= in_win;
            active_q      <= act;
            hs_q          <= hs_flag;
            vs_q          <= vs_flag;
            fs_q          <= (h == '0) && (v == '0);
            pix_q         <= pix_d;
            hsync_q       <= hs_q ? HS_ACTIVE_HIGH : ~HS_ACTIVE_HIGH;
            vsync_q       <= vs_q ? VS_ACTIVE_HIGH : ~VS_ACTIVE_HIGH;
            frame_start_q <= fs_q;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign red         = pix_q[RED_MSB:RED_LSB];
    assign green       = pix_q[GRN_MSB:GRN_LSB];
    assign blue        = pix_q[BLU_MSB:BLU_LSB];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign hcount      = h;
    assign vcount      = v;

endmodule

// File: tb/tb_vga_window_timing.sv
// Directed bench: a tiny active-high instance for reset behaviour and a
// full-width, short-frame instance for sync timing, windowing and clipping.
module tb_vga_window_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Small instance: H 8/2/2/2 (14), V 4/1/1/1 (7), 4x2 image, syncs active high.
    logic        rst_s;
    logic [15:0] rom_addr_s;
    logic [7:0]  rom_data_s;
    logic [2:0]  red_s, green_s;
    logic [1:0]  blue_s;
    logic        hsync_s, vsync_s, fs_s;
    logic [10:0] hcount_s;
    logic [9:0]  vcount_s;
    assign rom_data_s = rom_addr_s[7:0];

    vga_window_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_ACTIVE_HIGH(1'b1), .VS_ACTIVE_HIGH(1'b1),
        .IMG_W(4), .IMG_H(2), .ADDR_W(16)
    ) u_small (
        .clk(clk), .reset(rst_s), .img_x(11'd0), .img_y(10'd0), .bg_color(8'hE0),
        .rom_addr(rom_addr_s), .rom_data(rom_data_s),
        .red(red_s), .green(green_s), .blue(blue_s),
        .hsync(hsync_s), .vsync(vsync_s), .frame_start(fs_s),
        .hcount(hcount_s), .vcount(vcount_s)
    );

    // Main instance: default 1056-cycle lines, V 14/1/4/1 (20 lines), 168x3 image.
    logic        rst_m;
    logic [10:0] img_x_m;
    logic [9:0]  img_y_m;
    logic [15:0] rom_addr_m;
    logic [7:0]  rom_data_m;
    logic [2:0]  red_m, green_m;
    logic [1:0]  blue_m;
    logic        hsync_m, vsync_m, fs_m;
    logic [10:0] hcount_m;
    logic [9:0]  vcount_m;
    assign rom_data_m = rom_addr_m[7:0];

    vga_window_timing #(
        .V_ACTIVE(14), .V_FP(1), .V_SYNC(4), .V_BP(1), .IMG_H(3)
    ) u_main (
        .clk(clk), .reset(rst_m), .img_x(img_x_m), .img_y(img_y_m), .bg_color(8'h04),
        .rom_addr(rom_addr_m), .rom_data(rom_data_m),
        .red(red_m), .green(green_m), .blue(blue_m),
        .hsync(hsync_m), .vsync(vsync_m), .frame_start(fs_m),
        .hcount(hcount_m), .vcount(vcount_m)
    );

    // Edges since each reset release.
    int cyc_s, cyc_m;
    always_ff @(posedge clk or negedge rst_s)
        if (!rst_s) cyc_s <= 0; else cyc_s <= cyc_s + 1;
    always_ff @(posedge clk or negedge rst_m)
        if (!rst_m) cyc_m <= 0; else cyc_m <= cyc_m + 1;

    localparam int LINE  = 1056;
    localparam int FRAME = 1056 * 20;

    // Edge after which pin pixel (h,v) of frame fr is visible on the main instance.
    function automatic int pe(input int fr, input int h, input int v);
        return fr * FRAME + v * LINE + h + 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_s(input int n);
        while (cyc_s < n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_m(input int n);
        while (cyc_m < n) begin @(posedge clk); #1; end
    endtask

    task automatic pix_m(input string tag, input int n, input logic [7:0] exp);
        wait_m(n);
        check(tag, {red_m, green_m, blue_m}, exp);
    endtask

    initial begin
        rst_s = 1'b1; rst_m = 1'b1;
        img_x_m = 11'd10; img_y_m = 10'd10;
        #1;
        rst_s = 1'b0; rst_m = 1'b0;
        #1;
        check("rst_m_hsync", hsync_m, 1);
        check("rst_m_vsync", vsync_m, 1);
        check("rst_m_fs", fs_m, 0);
        check("rst_m_addr", rom_addr_m, 0);
        check("rst_m_rgb", {red_m, green_m, blue_m}, 0);
        check("rst_s_hsync", hsync_s, 0);
        check("rst_s_hcount", hcount_s, 0);

        // ---- small instance ----
        #20 rst_s = 1'b1;
        wait_s(2);   check("s_fs_e2", fs_s, 1);
        check("s_pix_0_0", {red_s, green_s, blue_s}, 8'h00);
        wait_s(3);   check("s_fs_e3", fs_s, 0);
        check("s_pix_1_0", {red_s, green_s, blue_s}, 8'h01);
        wait_s(7);   check("s_pix_bg", {red_s, green_s, blue_s}, 8'hE0);
        wait_s(11);  check("s_hs_pre", hsync_s, 0);
        wait_s(12);  check("s_hs_on", hsync_s, 1);
        wait_s(14);  check("s_hs_off", hsync_s, 0);
        wait_s(17);  check("s_pix_1_1", {red_s, green_s, blue_s}, 8'h05);
        wait_s(71);  check("s_vs_pre", vsync_s, 0);
        wait_s(72);  check("s_vs_on", vsync_s, 1);
        wait_s(110);
        check("s_mid_hs", hsync_s, 1);
        check("s_mid_addr", rom_addr_s, 3);
        check("s_mid_hcount", hcount_s, 12);
        #3 rst_s = 1'b0;
        #1;
        check("s_arst_hs", hsync_s, 0);
        check("s_arst_addr", rom_addr_s, 0);
        check("s_arst_hcount", hcount_s, 0);
        check("s_arst_vs_fs", {vsync_s, fs_s}, 0);
        #10 rst_s = 1'b1;
        wait_s(1);   check("s_re_fs_e1", fs_s, 0);
        wait_s(2);   check("s_re_fs_e2", fs_s, 1);
        wait_s(11);  check("s_re_hs_pre", hsync_s, 0);
        wait_s(12);  check("s_re_hs_on", hsync_s, 1);

        // ---- main instance ----
        @(negedge clk);
        rst_m = 1'b1;
        wait_m(1);   check("m_fs_e1", fs_m, 0);
        pix_m("m_f1_0_0", pe(0, 0, 0), 8'h00);
        check("m_fs_e2", fs_m, 1);
        pix_m("m_f1_1_0", pe(0, 1, 0), 8'h01);
        check("m_fs_e3", fs_m, 0);
        pix_m("m_f1_168_0_bg", pe(0, 168, 0), 8'h04);
        wait_m(841);  check("m_hs_841", hsync_m, 1);
        wait_m(842);  check("m_hs_842", hsync_m, 0);
        wait_m(969);  check("m_hs_969", hsync_m, 0);
        wait_m(970);  check("m_hs_970", hsync_m, 1);
        wait_m(1060); check("m_count_1060", {hcount_m, vcount_m}, {11'd4, 10'd1});
        pix_m("m_f1_5_1", pe(0, 5, 1), 8'hAD);
        wait_m(1897); check("m_hs_1897", hsync_m, 1);
        wait_m(1898); check("m_hs_1898", hsync_m, 0);
        wait_m(15841); check("m_vs_pre", vsync_m, 1);
        wait_m(15842); check("m_vs_on", vsync_m, 0);
        wait_m(20065); check("m_vs_last", vsync_m, 0);
        wait_m(20066); check("m_vs_off", vsync_m, 1);
        wait_m(FRAME); check("m_count_wrap", {hcount_m, vcount_m}, 0);
        wait_m(FRAME + 1); check("m_fs_pre2", fs_m, 0);
        wait_m(FRAME + 2); check("m_fs_2", fs_m, 1);

        // Frame 2: window at (10,10).
        pix_m("m_f2_9_10_bg", pe(1, 9, 10), 8'h04);
        pix_m("m_f2_10_10", pe(1, 10, 10), 8'h00);
        pix_m("m_f2_177_10", pe(1, 177, 10), 8'hA7);
        pix_m("m_f2_178_10_bg", pe(1, 178, 10), 8'h04);
        pix_m("m_f2_blank", pe(1, 900, 10), 8'h00);
        pix_m("m_f2_10_11", pe(1, 10, 11), 8'hA8);
        img_x_m = 11'd700;
        pix_m("m_f2_10_12", pe(1, 10, 12), 8'h50);
        wait_m(pe(1, 177, 12) - 1); check("m_f2_last_addr", rom_addr_m, 503);
        pix_m("m_f2_177_12", pe(1, 177, 12), 8'hF7);
        pix_m("m_f2_700_12_bg", pe(1, 700, 12), 8'h04);

        // Frame 3: window moved to x=700, right part clipped.
        pix_m("m_f3_699_10_bg", pe(2, 699, 10), 8'h04);
        pix_m("m_f3_700_10", pe(2, 700, 10), 8'h00);
        pix_m("m_f3_799_10", pe(2, 799, 10), 8'h63);
        pix_m("m_f3_800_10_clip", pe(2, 800, 10), 8'h00);
        wait_m(pe(2, 700, 11) - 1); check("m_f3_row1_addr", rom_addr_m, 168);
        pix_m("m_f3_700_11", pe(2, 700, 11), 8'hA8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
